// File: rtl/dpa_pkg.sv
// Shared photo-album definitions: glyph geometry, frame-buffer stride and the
// time_render state encoding, plus the character-ROM address helper.
package dpa_pkg;

    localparam int GLYPH_W     = 13;
    localparam int GLYPH_H     = 24;
    localparam int GLYPH_COLON = 10;
    localparam int GLYPH_BLANK = 11;
    localparam int FB_SHIFT    = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        WRITE,
        DONE
    } tr_state_t;

    // ROM rows are stored glyph-major, GLYPH_H rows per glyph.
    function automatic logic [8:0] rom_addr(input logic [3:0] glyph, input logic [4:0] row);
        return 9'(glyph) * 9'(GLYPH_H) + 9'(row);
    endfunction

endpackage

// File: rtl/time_render_if.sv
// Bus bundle between time_render and its surroundings: album-controller
// handshake, character-ROM read port and image-memory write port.
interface time_render_if;

    logic        start;
    logic [23:0] time_bcd;
    logic [19:0] fb_base;
    logic        busy;
    logic        done;
    logic [8:0]  cr_a;
    logic [12:0] cr_q;
    logic [19:0] im_a;
    logic [23:0] im_d;
    logic        im_wen;

    // Controller / memory side.
    modport master (
        output start, time_bcd, fb_base, cr_q,
        input  busy, done, cr_a, im_a, im_d, im_wen
    );

    // Renderer side.
    modport slave (
        input  start, time_bcd, fb_base, cr_q,
        output busy, done, cr_a, im_a, im_d, im_wen
    );

endinterface

// File: rtl/time_glyph_sel.sv
// Maps a character position (0..7 of "HH:MM:SS") and the latched BCD time to
// a glyph code: digits 0-9, colon at positions 2 and 5, blank for nibbles > 9.
module time_glyph_sel
    import dpa_pkg::*;
(
    input  logic [2:0]  char_idx,
    input  logic [23:0] time_bcd,
    output logic [3:0]  glyph
);

    logic [3:0] nib;

    // Pick the BCD nibble for this position, then apply colon / blank rules.
    always_comb begin
        nib   = 4'd0;
        glyph = 4'd0;
        case (char_idx)
            3'd0:    nib = time_bcd[23:20];
            3'd1:    nib = time_bcd[19:16];
            3'd3:    nib = time_bcd[15:12];
            3'd4:    nib = time_bcd[11:8];
            3'd6:    nib = time_bcd[7:4];
            3'd7:    nib = time_bcd[3:0];
            default: nib = 4'd0;
        endcase
        if (char_idx == 3'd2 || char_idx == 3'd5)
            glyph = 4'(GLYPH_COLON);
        else if (nib > 4'd9)
            glyph = 4'(GLYPH_BLANK);
        else
            glyph = nib;
    end

endmodule

// File: rtl/time_render.sv
// Renders "HH:MM:SS" into the frame buffer, one pixel per cycle, from
// character-ROM glyph rows. Optional macro TIME_RENDER_BG_EN paints clear
// pixels with BG (opaque box); otherwise clear pixels are skipped.
// Outputs are registered from next-state values so each cycle's cr_a / im_*
// belong to the state the block is in during that cycle.
module time_render
    import dpa_pkg::*;
#(
    parameter int          X0 = 8,
    parameter int          Y0 = 8,
    parameter logic [23:0] FG = 24'hFFFFFF,
    parameter logic [23:0] BG = 24'h000000
) (
    input logic          clk,
    input logic          reset,
    time_render_if.slave bus
);

    tr_state_t   state, state_n;
    logic [2:0]  char_q, char_n;
    logic [4:0]  row_q, row_n;
    logic [3:0]  col_q, col_n;
    logic [12:0] bits_q, bits_n;
    logic [23:0] time_q, time_n;
    logic [19:0] base_q, base_n;

    logic [3:0]  glyph;
    logic        pix;
    logic [23:0] pix_col;
    logic [19:0] pix_x, pix_y, pix_addr;

    time_glyph_sel u_glyph_sel (
        .char_idx (char_n),
        .time_bcd (time_n),
        .glyph    (glyph)
    );

    // Next-state and counter sequencing: FETCH, LATCH, then 13 WRITE cycles per row.
    always_comb begin
        state_n = state;
        char_n  = char_q;
        row_n   = row_q;
        col_n   = col_q;
        bits_n  = bits_q;
        time_n  = time_q;
        base_n  = base_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = FETCH;
                    time_n  = bus.time_bcd;
                    base_n  = bus.fb_base;
                    char_n  = 3'd0;
                    row_n   = 5'd0;
                end
            end
            FETCH: state_n = LATCH;
            LATCH: begin
                bits_n  = bus.cr_q;
                col_n   = 4'd0;
                state_n = WRITE;
            end
            WRITE: begin
                if (col_q == 4'(GLYPH_W - 1)) begin
                    if (row_q != 5'(GLYPH_H - 1)) begin
                        row_n   = row_q + 5'd1;
                        state_n = FETCH;
                    end else if (char_q != 3'd7) begin
                        char_n  = char_q + 3'd1;
                        row_n   = 5'd0;
                        state_n = FETCH;
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    col_n = col_q + 4'd1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Pixel value and address for the upcoming cycle; MSB of the row is the leftmost pixel.
    always_comb begin
        pix      = bits_n[4'd12 - col_n];
        pix_col  = pix ? FG : BG;
        pix_x    = 20'(X0) + 20'(char_n) * 20'(GLYPH_W) + 20'(col_n);
        pix_y    = (20'(Y0) + 20'(row_n)) << FB_SHIFT;
        pix_addr = base_n + pix_y + pix_x;
    end

    // Control state and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            char_q <= 3'd0;
            row_q  <= 5'd0;
            col_q  <= 4'd0;
        end else begin
            state  <= state_n;
            char_q <= char_n;
            row_q  <= row_n;
            col_q  <= col_n;
        end
    end

    // Latched request data and the captured glyph row.
    always_ff @(posedge clk) begin
        bits_q <= bits_n;
        time_q <= time_n;
        base_q <= base_n;
    end

    // Registered outputs; address/data hold outside the states that drive them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.cr_a   <= 9'd0;
            bus.im_a   <= 20'd0;
            bus.im_d   <= 24'd0;
            bus.im_wen <= 1'b1;
        end else begin
            bus.busy <= (state_n != IDLE);
            bus.done <= (state_n == DONE);
            if (state_n == FETCH)
                bus.cr_a <= rom_addr(glyph, row_n);
            if (state_n == WRITE) begin
                bus.im_a <= pix_addr;
`ifdef TIME_RENDER_BG_EN
                bus.im_wen <= 1'b0;
                bus.im_d   <= pix_col;
`else
                bus.im_wen <= ~pix;
                if (pix)
                    bus.im_d <= pix_col;
`endif
            end else begin
                bus.im_wen <= 1'b1;
            end
        end
    end

endmodule
